// File: rtl/lfsr_checker.sv
// Receive-side checker for the XNOR Fibonacci LFSR pattern generator: self-synchronises
// from the incoming stream, then flywheels on its own predictions and counts bit errors.
module lfsr_checker #(
  parameter int NUM_BITS = 32,
  parameter int GOOD_CNT = 16,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 4,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             E,
  input  logic             D,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [1:0]       STATE
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [63:0] tap(input int t);
    return 64'd1 << (t - 1);
  endfunction

  // Same tap table as the generator; an all-zero mask marks an unsupported length.
  function automatic logic [63:0] tap_mask(input int n);
    case (n)
      3:  return tap(3)  | tap(2);
      4:  return tap(4)  | tap(3);
      5:  return tap(5)  | tap(3);
      6:  return tap(6)  | tap(5);
      7:  return tap(7)  | tap(6);
      8:  return tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  return tap(9)  | tap(5);
      10: return tap(10) | tap(7);
      11: return tap(11) | tap(9);
      12: return tap(12) | tap(6)  | tap(4)  | tap(1);
      13: return tap(13) | tap(4)  | tap(3)  | tap(1);
      14: return tap(14) | tap(5)  | tap(3)  | tap(1);
      15: return tap(15) | tap(14);
      16: return tap(16) | tap(15) | tap(13) | tap(4);
      17: return tap(17) | tap(14);
      18: return tap(18) | tap(11);
      19: return tap(19) | tap(6)  | tap(2)  | tap(1);
      20: return tap(20) | tap(17);
      21: return tap(21) | tap(19);
      22: return tap(22) | tap(21);
      23: return tap(23) | tap(18);
      24: return tap(24) | tap(23) | tap(22) | tap(17);
      25: return tap(25) | tap(22);
      26: return tap(26) | tap(6)  | tap(2)  | tap(1);
      27: return tap(27) | tap(5)  | tap(2)  | tap(1);
      28: return tap(28) | tap(25);
      29: return tap(29) | tap(27);
      30: return tap(30) | tap(6)  | tap(4)  | tap(1);
      31: return tap(31) | tap(28);
      32: return tap(32) | tap(22) | tap(2)  | tap(1);
      64: return tap(64) | tap(63) | tap(61) | tap(60);
      default: return 64'd0;
    endcase
  endfunction

  localparam logic [63:0]         MASK      = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS:1]   TAPS      = MASK[NUM_BITS-1:0];
  localparam int                  FILL_W    = $clog2(NUM_BITS + 1);
  localparam logic [FILL_W-1:0]   FILL_LAST = FILL_W'(NUM_BITS - 1);
  localparam logic [7:0]          GOOD_LAST = 8'(GOOD_CNT - 1);
  localparam logic [15:0]         WIN_LAST  = 16'(WIN - 1);
  localparam logic [15:0]         LOSS_LIM  = 16'(LOSS_THR);

  if (MASK == 64'd0 || GOOD_CNT < 1 || GOOD_CNT > 255 || WIN < 2 || WIN > 65535 ||
      LOSS_THR < 1 || LOSS_THR > WIN || CNT_W < 1) begin : g_bad_param
    $error("lfsr_checker: unsupported parameter set");
  end

  state_t              state, state_n;
  logic [NUM_BITS:1]   r, r_n, shifted_d;
  logic [FILL_W-1:0]   fill_cnt, fill_n;
  logic [7:0]          good_cnt, good_n;
  logic [15:0]         win_cnt, win_n;
  logic [15:0]         werr_cnt, werr_n, werr_inc;
  logic                pred, miss, err_n;
  logic                locked_q, err_q;
  logic [CNT_W-1:0]    err_cnt_q;

  assign pred      = ~^(r & TAPS);
  assign miss      = D ^ pred;
  assign shifted_d = {r[NUM_BITS-1:1], D};
  assign werr_inc  = werr_cnt + 16'(miss);

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_n = state;
    r_n     = r;
    fill_n  = fill_cnt;
    good_n  = good_cnt;
    win_n   = win_cnt;
    werr_n  = werr_cnt;
    err_n   = 1'b0;
    if (E) begin
      unique case (state)
        ST_FILL: begin
          r_n = shifted_d;
          if (fill_cnt == FILL_LAST) begin
            fill_n = '0;
            // All-ones is the XNOR lockup state: it would predict itself forever.
            if (!(&shifted_d)) begin
              state_n = ST_VERIFY;
              good_n  = '0;
            end
          end else begin
            fill_n = fill_cnt + 1'b1;
          end
        end
        ST_VERIFY: begin
          r_n = shifted_d;
          if (!miss) begin
            if (good_cnt == GOOD_LAST) begin
              state_n = ST_LOCKED;
              win_n   = '0;
              werr_n  = '0;
            end else begin
              good_n = good_cnt + 1'b1;
            end
          end else begin
            state_n = ST_FILL;
            fill_n  = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: shift in the prediction so a line error never corrupts R.
          r_n   = {r[NUM_BITS-1:1], pred};
          err_n = miss;
          if (werr_inc == LOSS_LIM) begin
            state_n = ST_FILL;
            fill_n  = '0;
          end else if (win_cnt == WIN_LAST) begin
            win_n  = '0;
            werr_n = '0;
          end else begin
            win_n  = win_cnt + 1'b1;
            werr_n = werr_inc;
          end
        end
        default: state_n = ST_FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_FILL;
      r         <= '0;
      fill_cnt  <= '0;
      good_cnt  <= '0;
      win_cnt   <= '0;
      werr_cnt  <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state    <= state_n;
      r        <= r_n;
      fill_cnt <= fill_n;
      good_cnt <= good_n;
      win_cnt  <= win_n;
      werr_cnt <= werr_n;
      locked_q <= (state_n == ST_LOCKED);
      err_q    <= err_n;
      if (CLR_CNT)
        err_cnt_q <= CNT_W'(err_n);
      else if (err_n && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign LOCKED  = locked_q;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
  assign STATE   = state;

endmodule
